// File: rtl/guess_pkg.sv
// Shared types and defaults for the guess-the-number game datapath.
package guess_pkg;

  localparam int unsigned DEF_WIDTH     = 6;
  localparam int unsigned DEF_MAX_TRIES = 8;
  localparam int unsigned DEF_TRY_W     = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    WIN  = 2'd2,
    LOSE = 2'd3
  } state_e;

  // Three-way compare result, also consumed by the display decoder
  typedef enum logic [1:0] {
    LT = 2'd0,
    EQ = 2'd1,
    GT = 2'd2
  } cmp_t;

  typedef struct packed {
    logic too_high;
    logic too_low;
    logic correct;
  } flags_t;

endpackage

// File: rtl/guess_checker_if.sv
// Guess handshake and result bus between the player-side logic and the checker.
interface guess_checker_if #(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned TRY_W = 8
);

  logic [WIDTH-1:0] guess;
  logic             guess_valid;
  logic             guess_ready;
  logic             result_valid;
  logic             too_high;
  logic             too_low;
  logic             correct;
  logic             game_over;
  logic [TRY_W-1:0] tries;
  logic [WIDTH-1:0] secret_out;

  modport master (
    output guess, guess_valid,
    input  guess_ready, result_valid, too_high, too_low, correct,
           game_over, tries, secret_out
  );

  modport slave (
    input  guess, guess_valid,
    output guess_ready, result_valid, too_high, too_low, correct,
           game_over, tries, secret_out
  );

endinterface

// File: rtl/guess_cmp.sv
// Combinational unsigned three-way compare of a guess against the secret.
module guess_cmp
  import guess_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] guess,
  input  logic [WIDTH-1:0] secret,
  output cmp_t             cmp_c
);

  always_comb begin
    cmp_c = EQ;
    if (guess > secret) begin
      cmp_c = GT;
    end else if (guess < secret) begin
      cmp_c = LT;
    end
  end

endmodule

// File: rtl/guess_checker.sv
// Game controller: captures the secret on start, grades guesses, counts tries
// and ends the game on a win or when the try budget runs out.
module guess_checker
  import guess_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned MAX_TRIES = DEF_MAX_TRIES,
  parameter int unsigned TRY_W     = DEF_TRY_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] rand_in,
  input  logic             start,
  guess_checker_if.slave   gif
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] secret_q, secret_d;
  logic [TRY_W-1:0] tries_q, tries_d;
  flags_t           flags_q, flags_d;
  logic             result_valid_q, result_valid_d;
  logic             guess_ready_q, guess_ready_d;
  logic             game_over_q, game_over_d;
  logic [WIDTH-1:0] secret_out_q, secret_out_d;

  cmp_t             cmp_c;
  logic             handshake_c;
  logic [TRY_W-1:0] tries_inc_c;

  guess_cmp #(.WIDTH(WIDTH)) u_cmp (
    .guess  (gif.guess),
    .secret (secret_q),
    .cmp_c  (cmp_c)
  );

  // guess_ready_q mirrors state_q==PLAY; start pre-empts any handshake
  assign handshake_c = gif.guess_valid && guess_ready_q && !start;
  assign tries_inc_c = tries_q + TRY_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = PLAY;
    end else begin
      case (state_q)
        PLAY: begin
          if (handshake_c) begin
            if (cmp_c == EQ) begin
              state_d = WIN;
            end else if (tries_inc_c == TRY_W'(MAX_TRIES)) begin
              state_d = LOSE;
            end
          end
        end
        IDLE, WIN, LOSE: state_d = state_q;
        default:         state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    secret_d       = secret_q;
    tries_d        = tries_q;
    flags_d        = flags_q;
    result_valid_d = 1'b0;
    if (start) begin
      secret_d = rand_in;
      tries_d  = '0;
      flags_d  = '0;
    end else if (handshake_c) begin
      tries_d          = tries_inc_c;
      flags_d.too_high = (cmp_c == GT);
      flags_d.too_low  = (cmp_c == LT);
      flags_d.correct  = (cmp_c == EQ);
      result_valid_d   = 1'b1;
    end
    guess_ready_d = (state_d == PLAY);
    game_over_d   = (state_d == WIN) || (state_d == LOSE);
    secret_out_d  = game_over_d ? secret_d : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      secret_q       <= '0;
      tries_q        <= '0;
      flags_q        <= '0;
      result_valid_q <= 1'b0;
      guess_ready_q  <= 1'b0;
      game_over_q    <= 1'b0;
      secret_out_q   <= '0;
    end else begin
      secret_q       <= secret_d;
      tries_q        <= tries_d;
      flags_q        <= flags_d;
      result_valid_q <= result_valid_d;
      guess_ready_q  <= guess_ready_d;
      game_over_q    <= game_over_d;
      secret_out_q   <= secret_out_d;
    end
  end

  assign gif.guess_ready  = guess_ready_q;
  assign gif.result_valid = result_valid_q;
  assign gif.too_high     = flags_q.too_high;
  assign gif.too_low      = flags_q.too_low;
  assign gif.correct      = flags_q.correct;
  assign gif.game_over    = game_over_q;
  assign gif.tries        = tries_q;
  assign gif.secret_out   = secret_out_q;

endmodule
